fir_batch_ctrl: RTL and testbench
=================================

// Module: fir_batch_ctrl
// PURPOSE
// Multi-channel successor of the single-job FIR controller FSM. One start runs up to MAX_CH
// independent signals back-to-back. Per channel it sequences tap loading, X/H/Y streamer starts
// and completion, advancing base addresses by programmable strides.
// Optional tap reuse loads H once for all channels. Sits between the hwpe_ctrl_slave regfile
// decode and the streamer/tap buffer/datapath.
// PARAMETERS
// MAX_TAPS  64  max taps accepted; cfg_nb_taps_i above this is a config error
// MAX_CH    8   max channels per job
// LEN_W     16  width of sample counts (16-bit samples)
// ADDR_W    32  byte-address width
// SHIFT_W   6   datapath right-shift width
// PORTS
// clk_i          in  1        clock
// rst_i          in  1        sync active-high reset
// clear_i        in  1        soft clear from slave; same effect as rst_i
// start_i        in  1        job start pulse from slave
// cfg_x_addr_i / cfg_h_addr_i / cfg_y_addr_i  in  ADDR_W  channel-0 base addresses
// cfg_x_stride_i / cfg_h_stride_i / cfg_y_stride_i  in  ADDR_W  byte offset between channels
// cfg_len_i      in  LEN_W    samples per channel
// cfg_nb_taps_i  in  $clog2(MAX_TAPS+1)  taps
// cfg_nb_ch_i    in  $clog2(MAX_CH+1)  channel count
// cfg_reuse_i    in  1        1: taps loaded for ch 0 only
// cfg_shift_i    in  SHIFT_W  right shift
// tap_done_i     in  1        tap buffer filled
// y_done_i       in  1        Y sink finished
// x_start_o / h_start_o / y_start_o  out  1  streamer req_start pulses
// x_base_o / h_base_o / y_base_o     out  ADDR_W  current-channel bases
// xy_words_o     out  LEN_W   32-bit words for X and Y
// h_words_o      out  LEN_W   32-bit words for H
// right_shift_o  out  SHIFT_W  latched shift
// ch_idx_o       out  $clog2(MAX_CH)  active channel
// busy_o         out  1        not IDLE
// done_o         out  1        job-end pulse (to slave done/evt)
// err_o          out  1        config-error pulse, coincident with done_o
// BEHAVIOUR
// - All outputs registered (Moore); rst_i/clear_i: state IDLE, all outputs 0, no done_o.
// - start_i in IDLE latches all cfg_* into shadow regs; cfg_* then ignored until IDLE.
//   start_i outside IDLE is ignored.
// - Config check at start: len==0, nb_taps==0, nb_taps>MAX_TAPS, nb_ch==0 or nb_ch>MAX_CH.
//   Any failure -> next cycle done_o=err_o=1 for 1 cycle, stay IDLE, no streamer start.
// - States: IDLE, TAPS, COMPUTE, NEXT.
//   - IDLE -start ok-> TAPS.
//   - TAPS -tap_done_i-> COMPUTE.
//   - COMPUTE -y_done_i & last ch-> IDLE.
//   - COMPUTE -y_done_i & not last-> NEXT.
//   - NEXT -> TAPS if !reuse, else -> COMPUTE (1 cycle).
// - Channel entry (IDLE->TAPS or NEXT->*): x_start_o=y_start_o=1 for exactly 1 cycle.
//   h_start_o=1 only on entry to TAPS. Start pulse = cycle after start_i/NEXT.
// - xy_words_o=(len+1)>>1 and h_words_o=(nb_taps+1)>>1, i.e. ceil; odd counts round up.
// - Channel 0: bases = cfg addrs. In NEXT: ch_idx+=1, x_base+=x_stride, y_base+=y_stride.
//   h_base+=h_stride only if !reuse. Adds wrap modulo 2^ADDR_W.
// - done_o pulses 1 cycle after y_done_i of the last channel; busy_o drops the same cycle.
// - tap_done_i outside TAPS and y_done_i outside COMPUTE are ignored. Both same cycle in TAPS:
//   tap_done_i taken, y_done_i dropped.
// - clear_i mid-job: IDLE next cycle, no done_o, shadow regs left stale.
// STRUCTURE
// - fir_package gains fir_batch_state_t (IDLE/TAPS/COMPUTE/NEXT) and fir_batch_cfg_t (shadow config).
// - Sub-module fir_batch_addr_acc: per-stream base register with load/advance, instanced x3.
// TESTING
// - len=7, taps=4, nb_ch=1, reuse=0 -> x/h/y_start once; xy_words=4, h_words=2;
//   done_o 1 cycle after y_done_i.
// - nb_ch=3, reuse=0, x_stride=0x100, h_stride=0x40 -> 3 h_start pulses;
//   x_base = X, X+0x100, X+0x200.
// - nb_ch=3, reuse=1 -> 1 h_start, 3 x_start; h_base constant; TAPS visited once.
// - nb_taps=MAX_TAPS+1, or nb_ch=0 -> err_o=done_o=1 one cycle; no *_start; busy_o stays 0.
// - clear_i in COMPUTE of ch 1 -> IDLE next cycle, no done_o; next start runs cleanly from ch 0.
// - start_i during COMPUTE with changed cfg_* -> ignored; running job uses latched values.

Source files
------------

// File: rtl/fir_batch_ctrl_pkg.sv
// Shared types, sizes and helpers for the multi-channel FIR batch controller.
package fir_batch_ctrl_pkg;

  localparam int unsigned MAX_TAPS = 64;
  localparam int unsigned MAX_CH   = 8;
  localparam int unsigned LEN_W    = 16;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned SHIFT_W  = 6;
  localparam int unsigned TAPS_W   = $clog2(MAX_TAPS + 1);
  localparam int unsigned CH_W     = $clog2(MAX_CH + 1);
  localparam int unsigned IDX_W    = $clog2(MAX_CH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAPS    = 2'd1,
    COMPUTE = 2'd2,
    NEXT    = 2'd3
  } fir_batch_state_t;

  // Job-wide settings still needed after the start cycle.
  typedef struct packed {
    logic [ADDR_W-1:0] x_stride;
    logic [ADDR_W-1:0] h_stride;
    logic [ADDR_W-1:0] y_stride;
    logic [CH_W-1:0]   nb_ch;
    logic              reuse;
  } fir_batch_cfg_t;

  function automatic logic cfg_ok(input logic [LEN_W-1:0]  len,
                                  input logic [TAPS_W-1:0] taps,
                                  input logic [CH_W-1:0]   nb_ch);
    return (len != '0) && (taps != '0) && (taps <= TAPS_W'(MAX_TAPS)) &&
           (nb_ch != '0) && (nb_ch <= CH_W'(MAX_CH));
  endfunction

  // Two 16-bit samples per 32-bit word, odd counts round up.
  function automatic logic [LEN_W-1:0] ceil_half(input logic [LEN_W-1:0] n);
    logic [LEN_W:0] s;
    s = {1'b0, n} + (LEN_W + 1)'(1);
    return s[LEN_W:1];
  endfunction

endpackage

// File: rtl/fir_batch_addr_acc.sv
// Per-stream base address register: loaded with the channel-0 base, advanced by a stride.
module fir_batch_addr_acc
  import fir_batch_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              adv_i,
  input  logic [ADDR_W-1:0] stride_i,
  output logic [ADDR_W-1:0] base_o
);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      base_o <= '0;
    end else if (load_i) begin
      base_o <= load_val_i;
    end else if (adv_i) begin
      base_o <= base_o + stride_i;
    end
  end

endmodule

// File: rtl/fir_batch_ctrl.sv
// Multi-channel FIR job sequencer: runs up to MAX_CH channels back-to-back per start.
// state   | meaning
// IDLE    | waiting for start; config check happens here
// TAPS    | H streamer running, waiting for tap buffer fill
// COMPUTE | X/Y streamers running, waiting for Y sink completion
// NEXT    | one-cycle channel advance; relaunches streamers
module fir_batch_ctrl
  import fir_batch_ctrl_pkg::*;
#(
  parameter int unsigned MAX_TAPS = fir_batch_ctrl_pkg::MAX_TAPS,
  parameter int unsigned MAX_CH   = fir_batch_ctrl_pkg::MAX_CH,
  parameter int unsigned LEN_W    = fir_batch_ctrl_pkg::LEN_W,
  parameter int unsigned ADDR_W   = fir_batch_ctrl_pkg::ADDR_W,
  parameter int unsigned SHIFT_W  = fir_batch_ctrl_pkg::SHIFT_W
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         start_i,
  input  logic [ADDR_W-1:0]            cfg_x_addr_i,
  input  logic [ADDR_W-1:0]            cfg_h_addr_i,
  input  logic [ADDR_W-1:0]            cfg_y_addr_i,
  input  logic [ADDR_W-1:0]            cfg_x_stride_i,
  input  logic [ADDR_W-1:0]            cfg_h_stride_i,
  input  logic [ADDR_W-1:0]            cfg_y_stride_i,
  input  logic [LEN_W-1:0]             cfg_len_i,
  input  logic [$clog2(MAX_TAPS+1)-1:0] cfg_nb_taps_i,
  input  logic [$clog2(MAX_CH+1)-1:0]  cfg_nb_ch_i,
  input  logic                         cfg_reuse_i,
  input  logic [SHIFT_W-1:0]           cfg_shift_i,
  input  logic                         tap_done_i,
  input  logic                         y_done_i,
  output logic                         x_start_o,
  output logic                         h_start_o,
  output logic                         y_start_o,
  output logic [ADDR_W-1:0]            x_base_o,
  output logic [ADDR_W-1:0]            h_base_o,
  output logic [ADDR_W-1:0]            y_base_o,
  output logic [LEN_W-1:0]             xy_words_o,
  output logic [LEN_W-1:0]             h_words_o,
  output logic [SHIFT_W-1:0]           right_shift_o,
  output logic [$clog2(MAX_CH)-1:0]    ch_idx_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o
);

  fir_batch_state_t state_q, state_d;
  fir_batch_cfg_t   cfg_q;

  logic            srst;
  logic            latch, load, advance;
  logic            xy_pulse_d, h_pulse_d, done_d, err_d;
  logic [CH_W-1:0] ch_last;
  logic            is_last;

  assign srst    = rst_i | clear_i;
  assign ch_last = cfg_q.nb_ch - CH_W'(1);
  assign is_last = (CH_W'(ch_idx_o) == ch_last);

  always_comb begin
    state_d    = state_q;
    latch      = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    xy_pulse_d = 1'b0;
    h_pulse_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          latch = 1'b1;
          if (cfg_ok(cfg_len_i, cfg_nb_taps_i, cfg_nb_ch_i)) begin
            state_d    = TAPS;
            load       = 1'b1;
            xy_pulse_d = 1'b1;
            h_pulse_d  = 1'b1;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      TAPS: begin
        // y_done_i arriving here (even with tap_done_i) is deliberately dropped
        if (tap_done_i) state_d = COMPUTE;
      end
      COMPUTE: begin
        if (y_done_i) begin
          if (is_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        advance    = 1'b1;
        xy_pulse_d = 1'b1;
        if (cfg_q.reuse) begin
          state_d = COMPUTE;
        end else begin
          state_d   = TAPS;
          h_pulse_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst) begin
      state_q       <= IDLE;
      x_start_o     <= 1'b0;
      h_start_o     <= 1'b0;
      y_start_o     <= 1'b0;
      xy_words_o    <= '0;
      h_words_o     <= '0;
      right_shift_o <= '0;
      ch_idx_o      <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_start_o <= xy_pulse_d;
      y_start_o <= xy_pulse_d;
      h_start_o <= h_pulse_d;
      busy_o    <= (state_d != IDLE);
      done_o    <= done_d;
      err_o     <= err_d;
      if (load) begin
        xy_words_o    <= ceil_half(cfg_len_i);
        h_words_o     <= ceil_half(LEN_W'(cfg_nb_taps_i));
        right_shift_o <= cfg_shift_i;
        ch_idx_o      <= '0;
      end else if (advance) begin
        ch_idx_o <= ch_idx_o + 1'b1;
      end
    end
  end

  // Shadow config survives clear_i on purpose; only a full reset wipes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_q <= '0;
    end else if (latch) begin
      cfg_q.x_stride <= cfg_x_stride_i;
      cfg_q.h_stride <= cfg_h_stride_i;
      cfg_q.y_stride <= cfg_y_stride_i;
      cfg_q.nb_ch    <= cfg_nb_ch_i;
      cfg_q.reuse    <= cfg_reuse_i;
    end
  end

  fir_batch_addr_acc u_x_acc (
    .clk_i      (clk_i),
    .srst_i     (srst),
    .load_i     (load),
    .load_val_i (cfg_x_addr_i),
    .adv_i      (advance),
    .stride_i   (cfg_q.x_stride),
    .base_o     (x_base_o)
  );

  fir_batch_addr_acc u_h_acc (
    .clk_i      (clk_i),
    .srst_i     (srst),
    .load_i     (load),
    .load_val_i (cfg_h_addr_i),
    .adv_i      (advance & ~cfg_q.reuse),
    .stride_i   (cfg_q.h_stride),
    .base_o     (h_base_o)
  );

  fir_batch_addr_acc u_y_acc (
    .clk_i      (clk_i),
    .srst_i     (srst),
    .load_i     (load),
    .load_val_i (cfg_y_addr_i),
    .adv_i      (advance),
    .stride_i   (cfg_q.y_stride),
    .base_o     (y_base_o)
  );

endmodule

// File: tb/tb_fir_batch_ctrl.sv
// Directed self-checking bench for fir_batch_ctrl.
module tb_fir_batch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i, clear_i, start_i;
  logic [31:0] cfg_x_addr_i, cfg_h_addr_i, cfg_y_addr_i;
  logic [31:0] cfg_x_stride_i, cfg_h_stride_i, cfg_y_stride_i;
  logic [15:0] cfg_len_i;
  logic [6:0]  cfg_nb_taps_i;
  logic [3:0]  cfg_nb_ch_i;
  logic        cfg_reuse_i;
  logic [5:0]  cfg_shift_i;
  logic        tap_done_i, y_done_i;
  logic        x_start_o, h_start_o, y_start_o;
  logic [31:0] x_base_o, h_base_o, y_base_o;
  logic [15:0] xy_words_o, h_words_o;
  logic [5:0]  right_shift_o;
  logic [2:0]  ch_idx_o;
  logic        busy_o, done_o, err_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_x = 0, cnt_h = 0, cnt_y = 0, cnt_done = 0, cnt_err = 0;
  int sx, sh, sy, sd, se;

  fir_batch_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .cfg_x_addr_i(cfg_x_addr_i), .cfg_h_addr_i(cfg_h_addr_i), .cfg_y_addr_i(cfg_y_addr_i),
    .cfg_x_stride_i(cfg_x_stride_i), .cfg_h_stride_i(cfg_h_stride_i),
    .cfg_y_stride_i(cfg_y_stride_i), .cfg_len_i(cfg_len_i), .cfg_nb_taps_i(cfg_nb_taps_i),
    .cfg_nb_ch_i(cfg_nb_ch_i), .cfg_reuse_i(cfg_reuse_i), .cfg_shift_i(cfg_shift_i),
    .tap_done_i(tap_done_i), .y_done_i(y_done_i),
    .x_start_o(x_start_o), .h_start_o(h_start_o), .y_start_o(y_start_o),
    .x_base_o(x_base_o), .h_base_o(h_base_o), .y_base_o(y_base_o),
    .xy_words_o(xy_words_o), .h_words_o(h_words_o), .right_shift_o(right_shift_o),
    .ch_idx_o(ch_idx_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Pulse counters, used for "how many starts happened" checks.
  always @(posedge clk_i) begin
    if (x_start_o === 1'b1) cnt_x    <= cnt_x + 1;
    if (h_start_o === 1'b1) cnt_h    <= cnt_h + 1;
    if (y_start_o === 1'b1) cnt_y    <= cnt_y + 1;
    if (done_o === 1'b1)    cnt_done <= cnt_done + 1;
    if (err_o === 1'b1)     cnt_err  <= cnt_err + 1;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic snap();
    sx = cnt_x; sh = cnt_h; sy = cnt_y; sd = cnt_done; se = cnt_err;
  endtask

  task automatic set_cfg(input logic [31:0] xa, ha, ya, xs, hs, ys,
                         input logic [15:0] len, input logic [6:0] taps,
                         input logic [3:0] nch, input logic reuse, input logic [5:0] sh_v);
    cfg_x_addr_i = xa; cfg_h_addr_i = ha; cfg_y_addr_i = ya;
    cfg_x_stride_i = xs; cfg_h_stride_i = hs; cfg_y_stride_i = ys;
    cfg_len_i = len; cfg_nb_taps_i = taps; cfg_nb_ch_i = nch;
    cfg_reuse_i = reuse; cfg_shift_i = sh_v;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Called just after a channel-entry edge; walks the channel through to its end.
  task automatic run_ch(input string tag, input logic [31:0] ex, eh, ey,
                        input logic [2:0] eidx, input logic eh_start, input logic last);
    chk({tag, ".x_start"}, x_start_o, 1);
    chk({tag, ".y_start"}, y_start_o, 1);
    chk({tag, ".h_start"}, h_start_o, eh_start);
    chk({tag, ".x_base"}, x_base_o, ex);
    chk({tag, ".h_base"}, h_base_o, eh);
    chk({tag, ".y_base"}, y_base_o, ey);
    chk({tag, ".ch_idx"}, ch_idx_o, eidx);
    chk({tag, ".busy"}, busy_o, 1);
    tick();
    chk({tag, ".x_start_low"}, x_start_o, 0);
    if (eh_start) begin
      tap_done_i = 1'b1;
      tick();
      tap_done_i = 1'b0;
    end
    y_done_i = 1'b1;
    tick();
    y_done_i = 1'b0;
    if (last) begin
      chk({tag, ".done"}, done_o, 1);
      chk({tag, ".busy_drop"}, busy_o, 0);
      chk({tag, ".err"}, err_o, 0);
      tick();
      chk({tag, ".done_low"}, done_o, 0);
    end else begin
      chk({tag, ".no_done"}, done_o, 0);
      chk({tag, ".busy_next"}, busy_o, 1);
      tick();
    end
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; tap_done_i = 1'b0; y_done_i = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst_i = 1'b0;
    chk("rst.busy", busy_o, 0);
    chk("rst.done", done_o, 0);
    chk("rst.x_start", x_start_o, 0);
    chk("rst.x_base", x_base_o, 0);
    chk("rst.xy_words", xy_words_o, 0);

    // Single channel, odd len, both done inputs together in TAPS.
    set_cfg(32'h1000, 32'h2000, 32'h3000, 0, 0, 0, 16'd7, 7'd4, 4'd1, 1'b0, 6'd3);
    snap();
    pulse_start();
    chk("t1.x_start", x_start_o, 1);
    chk("t1.h_start", h_start_o, 1);
    chk("t1.y_start", y_start_o, 1);
    chk("t1.xy_words", xy_words_o, 4);
    chk("t1.h_words", h_words_o, 2);
    chk("t1.shift", right_shift_o, 3);
    chk("t1.x_base", x_base_o, 32'h1000);
    chk("t1.h_base", h_base_o, 32'h2000);
    chk("t1.y_base", y_base_o, 32'h3000);
    chk("t1.busy", busy_o, 1);
    y_done_i = 1'b1;
    tick();
    y_done_i = 1'b0;
    chk("t1.ydone_in_taps_ignored", done_o, 0);
    tap_done_i = 1'b1; y_done_i = 1'b1;
    tick();
    tap_done_i = 1'b0; y_done_i = 1'b0;
    chk("t1.both_ydone_dropped", done_o, 0);
    chk("t1.busy_compute", busy_o, 1);
    y_done_i = 1'b1;
    tick();
    y_done_i = 1'b0;
    chk("t1.done", done_o, 1);
    chk("t1.busy_drop", busy_o, 0);
    tick();
    chk("t1.done_low", done_o, 0);
    chk("t1.n_x", cnt_x - sx, 1);
    chk("t1.n_h", cnt_h - sh, 1);
    chk("t1.n_y", cnt_y - sy, 1);
    chk("t1.n_done", cnt_done - sd, 1);

    // Three channels, taps reloaded each channel.
    set_cfg(32'h1000, 32'h2000, 32'h3000, 32'h100, 32'h40, 32'h80, 16'd5, 7'd3, 4'd3, 1'b0, 6'd1);
    snap();
    pulse_start();
    chk("t2.xy_words", xy_words_o, 3);
    chk("t2.h_words", h_words_o, 2);
    run_ch("t2.c0", 32'h1000, 32'h2000, 32'h3000, 0, 1, 0);
    run_ch("t2.c1", 32'h1100, 32'h2040, 32'h3080, 1, 1, 0);
    run_ch("t2.c2", 32'h1200, 32'h2080, 32'h3100, 2, 1, 1);
    chk("t2.n_h", cnt_h - sh, 3);
    chk("t2.n_x", cnt_x - sx, 3);
    chk("t2.n_done", cnt_done - sd, 1);

    // Three channels with tap reuse; x base wraps past 2^32.
    set_cfg(32'hFFFF_FF80, 32'h2000, 32'h3000, 32'h100, 32'h40, 32'h80, 16'd8, 7'd64, 4'd3, 1'b1, 6'd0);
    snap();
    pulse_start();
    chk("t3.xy_words", xy_words_o, 4);
    chk("t3.h_words", h_words_o, 32);
    run_ch("t3.c0", 32'hFFFF_FF80, 32'h2000, 32'h3000, 0, 1, 0);
    run_ch("t3.c1", 32'h0000_0080, 32'h2000, 32'h3080, 1, 0, 0);
    run_ch("t3.c2", 32'h0000_0180, 32'h2000, 32'h3100, 2, 0, 1);
    chk("t3.n_h", cnt_h - sh, 1);
    chk("t3.n_x", cnt_x - sx, 3);

    // Config errors: too many taps, then zero channels.
    set_cfg(32'h1000, 32'h2000, 32'h3000, 0, 0, 0, 16'd4, 7'd65, 4'd1, 1'b0, 6'd0);
    snap();
    pulse_start();
    chk("e1.done", done_o, 1);
    chk("e1.err", err_o, 1);
    chk("e1.busy", busy_o, 0);
    tick();
    chk("e1.done_low", done_o, 0);
    chk("e1.err_low", err_o, 0);
    cfg_nb_taps_i = 7'd4; cfg_nb_ch_i = 4'd0;
    pulse_start();
    chk("e2.done", done_o, 1);
    chk("e2.err", err_o, 1);
    chk("e2.busy", busy_o, 0);
    tick();
    cfg_nb_ch_i = 4'd9;
    pulse_start();
    chk("e3.err", err_o, 1);
    tick();
    chk("e.busy_idle", busy_o, 0);
    chk("e.n_x", cnt_x - sx, 0);
    chk("e.n_h", cnt_h - sh, 0);
    chk("e.n_err", cnt_err - se, 3);

    // Clear during COMPUTE of channel 1, then a clean single-channel job.
    set_cfg(32'h1000, 32'h2000, 32'h3000, 32'h100, 32'h40, 32'h80, 16'd2, 7'd2, 4'd3, 1'b0, 6'd0);
    pulse_start();
    run_ch("c.c0", 32'h1000, 32'h2000, 32'h3000, 0, 1, 0);
    chk("c.c1_idx", ch_idx_o, 1);
    tick();
    tap_done_i = 1'b1;
    tick();
    tap_done_i = 1'b0;
    snap();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("c.busy", busy_o, 0);
    chk("c.done", done_o, 0);
    chk("c.x_base", x_base_o, 0);
    chk("c.ch_idx", ch_idx_o, 0);
    y_done_i = 1'b1;
    tick();
    y_done_i = 1'b0;
    chk("c.no_done_after", cnt_done - sd, 0);
    cfg_nb_ch_i = 4'd1;
    pulse_start();
    run_ch("c.rerun", 32'h1000, 32'h2000, 32'h3000, 0, 1, 1);

    // start_i with new config mid-job must not disturb the running job.
    set_cfg(32'h4000, 32'h5000, 32'h6000, 32'h10, 32'h20, 32'h30, 16'd9, 7'd5, 4'd2, 1'b0, 6'd2);
    pulse_start();
    chk("s.xy_words", xy_words_o, 5);
    tap_done_i = 1'b1;
    tick();
    tap_done_i = 1'b0;
    set_cfg(32'h7000, 32'h8000, 32'h9000, 32'h1, 32'h1, 32'h1, 16'd1, 7'd1, 4'd1, 1'b1, 6'd7);
    snap();
    pulse_start();
    chk("s.no_restart", x_start_o, 0);
    chk("s.xy_keep", xy_words_o, 5);
    chk("s.shift_keep", right_shift_o, 2);
    y_done_i = 1'b1;
    tick();
    y_done_i = 1'b0;
    chk("s.not_done_ch0", done_o, 0);
    tick();
    run_ch("s.c1", 32'h4010, 32'h5020, 32'h6030, 1, 1, 1);
    chk("s.n_h", cnt_h - sh, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
